// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with one-entry result register and flags.
// Define ALU_MULDIV_EN to add iterative MUL/MULHU/DIVU/REMU (ops 9-12).
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       fop,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdb,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic accept, iter, last, load_res, sub, alu_v, alu_c;
  logic [WIDTH-1:0] bb, alu_res, iter_res, res_n;
  logic [WIDTH:0] sum;
  assign in_ready = nrst && (state == IDLE || (state == DONE && out_ready));
  assign accept = in_valid && in_ready && !kill;
  assign out_valid = state == DONE;
  always_comb begin
    sub = fop == 4'd1;
    bb = sub ? ~rdb : rdb;
    sum = {1'b0, rda} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    alu_v = fop <= 4'd1 && rda[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != rda[WIDTH-1];
    alu_c = fop <= 4'd1 && sum[WIDTH];
    alu_res = fop <= 4'd1 ? sum[WIDTH-1:0] :
              fop == 4'd2 ? rda << rdb[SHW-1:0] :
              fop == 4'd3 ? rda >> rdb[SHW-1:0] :
              fop == 4'd4 ? $unsigned($signed(rda) >>> rdb[SHW-1:0]) :
              fop == 4'd5 ? rda & rdb :
              fop == 4'd6 ? rda | rdb :
              fop == 4'd7 ? rda ^ rdb :
              fop == 4'd8 ? rdb : '0;
  end
`ifdef ALU_MULDIV_EN
  logic [SHW:0] cnt;
  logic [3:0] op;
  logic [WIDTH-1:0] acc, q, b, acc_n, q_n;
  logic [WIDTH:0] ms, ds;
  assign iter = fop >= 4'd9 && fop <= 4'd12;
  assign last = state == BUSY && cnt == 1;
  // acc/q hold {product high, low} for multiply and {remainder, quotient} for divide
  always_comb begin
    ms = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    ds = {acc, q[WIDTH-1]} - {1'b0, b};
    acc_n = op <= 4'd10 ? ms[WIDTH:1] : ds[WIDTH] ? {acc[WIDTH-2:0], q[WIDTH-1]} : ds[WIDTH-1:0];
    q_n = op <= 4'd10 ? {ms[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], !ds[WIDTH]};
    iter_res = op[0] ? q_n : acc_n;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
      op <= '0;
      acc <= '0;
      q <= '0;
      b <= '0;
    end else if (accept) begin
      cnt <= (SHW + 1)'(WIDTH);
      op <= fop;
      acc <= '0;
      q <= rda;
      b <= rdb;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      acc <= acc_n;
      q <= q_n;
    end
  end
`else
  assign iter = 1'b0;
  assign last = 1'b0;
  assign iter_res = '0;
`endif
  assign load_res = !kill && ((accept && !iter) || last);
  assign res_n = accept ? alu_res : iter_res;
  always_comb begin
    state_n = state;
    if (kill) state_n = IDLE;
    else if (accept) state_n = iter ? BUSY : DONE;
    else if (last) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      result <= '0;
      {Z, N, V, C} <= '0;
    end else begin
      state <= state_n;
      if (load_res) begin
        result <= res_n;
        Z <= res_n == '0;
        N <= res_n[WIDTH-1];
        V <= accept && alu_v;
        C <= accept && alu_c;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, directed corner sequences and random ops against a reference model.
module tb_alu_pipe;
  localparam int W = 32;
  logic clk = 0, nrst = 0, in_valid = 0, kill = 0, out_ready = 1;
  logic in_ready, out_valid, Z, N, V, C;
  logic [3:0] fop = 0;
  logic [W-1:0] rda = 0, rdb = 0, result;
  int n_checks = 0, n_fail = 0;

  typedef struct {
    logic [3:0] f;
    logic [31:0] a, b, r;
    logic z, n, v, c;
  } vec_t;
  vec_t vt[13];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .fop(fop),
    .rda(rda), .rdb(rdb), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .Z(Z), .N(N), .V(V), .C(C)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic bit is_iter(input logic [3:0] f);
`ifdef ALU_MULDIV_EN
    return f >= 9 && f <= 12;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic v, output logic c);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s = 0;
    logic [63:0] p = {32'd0, a} * {32'd0, b};
    r = 0; v = 0; c = 0;
    case (f)
      0: begin r = a + b; s = sa + sb; v = s != longint'($signed(r)); c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF; end
      1: begin r = a - b; s = sa - sb; v = s != longint'($signed(r)); c = a >= b; end
      2: r = a << b[4:0];
      3: r = a >> b[4:0];
      4: r = $signed(a) >>> b[4:0];
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = b;
`ifdef ALU_MULDIV_EN
      9: r = p[31:0];
      10: r = p[63:32];
      11: r = b == 0 ? 32'hFFFF_FFFF : a / b;
      12: r = b == 0 ? a : a % b;
`endif
      default: r = 0;
    endcase
  endfunction

  // Presents one op with out_ready high and waits for its result; inputs are scrambled after accept.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic en, input logic ev,
                        input logic ec, input string nm);
    int n;
    bit busy_rdy;
    in_valid = 1; fop = f; rda = a; rdb = b; out_ready = 1;
    tick;
    n = 1; busy_rdy = 0;
    in_valid = 0; fop = 4'($urandom); rda = $urandom; rdb = $urandom;
    while (!out_valid && n < 100) begin
      busy_rdy |= in_ready;
      tick;
      n++;
    end
    check({nm, "_lat"}, 64'(n), is_iter(f) ? 64'(W + 1) : 64'd1);
    check({nm, "_res"}, 64'(result), 64'(er));
    check({nm, "_flags"}, 64'({Z, N, V, C}), 64'({ez, en, ev, ec}));
    if (is_iter(f)) check({nm, "_busy_rdy"}, 64'(busy_rdy), 64'd0);
  endtask

  initial begin
    logic [31:0] r, a, b, hold;
    logic [3:0] f;
    logic v, c;
    bit seen;
    vt[0] = '{0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 1, 0};
    vt[1] = '{1, 32'd5, 32'd5, 32'd0, 1, 0, 0, 1};
    vt[2] = '{4, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1, 0, 0};
`ifdef ALU_MULDIV_EN
    vt[3] = '{9, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0, 1, 0, 0};
    vt[4] = '{10, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 0, 0, 0};
    vt[5] = '{11, 32'd100, 32'd7, 32'd14, 0, 0, 0, 0};
    vt[6] = '{12, 32'd100, 32'd7, 32'd2, 0, 0, 0, 0};
    vt[7] = '{11, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 1, 0, 0};
    vt[8] = '{12, 32'd7, 32'd0, 32'd7, 0, 0, 0, 0};
`else
    vt[3] = '{9, 32'hFFFF_FFFF, 32'd2, 32'd0, 1, 0, 0, 0};
    vt[4] = '{10, 32'hFFFF_FFFF, 32'd2, 32'd0, 1, 0, 0, 0};
    vt[5] = '{11, 32'd100, 32'd7, 32'd0, 1, 0, 0, 0};
    vt[6] = '{12, 32'd100, 32'd7, 32'd0, 1, 0, 0, 0};
    vt[7] = '{11, 32'd7, 32'd0, 32'd0, 1, 0, 0, 0};
    vt[8] = '{12, 32'd7, 32'd0, 32'd0, 1, 0, 0, 0};
`endif
    vt[9] = '{13, 32'h1234, 32'h5678, 32'd0, 1, 0, 0, 0};
    vt[10] = '{8, 32'd0, 32'h8000_0001, 32'h8000_0001, 0, 1, 0, 0};
    vt[11] = '{1, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1, 0, 0};
    vt[12] = '{2, 32'd1, 32'd33, 32'd2, 0, 0, 0, 0};

    tick; tick;
    check("rst_valid", 64'(out_valid), 0);
    check("rst_result", 64'(result), 0);
    check("rst_flags", 64'({Z, N, V, C}), 0);
    check("rst_ready", 64'(in_ready), 0);
    nrst = 1;
    tick;
    check("idle_ready", 64'(in_ready), 1);

    foreach (vt[i]) run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].r, vt[i].z, vt[i].n, vt[i].v, vt[i].c,
                           $sformatf("vec%0d", i));

    // back-to-back SUB then SRA, one result per cycle
    in_valid = 1; fop = 1; rda = 5; rdb = 5;
    tick;
    check("b2b_sub", 64'({out_valid, result, Z, C}), {1'b1, 32'd0, 2'b11});
    fop = 4; rda = 32'h8000_0000; rdb = 32'h24;
    tick;
    check("b2b_sra", 64'({out_valid, result, N}), {1'b1, 32'hF800_0000, 1'b1});
    in_valid = 0;
    tick;
    check("b2b_idle", 64'(out_valid), 0);

    // back-pressure: held result, held in_valid refused, accepted on release edge
    run_op(0, 1, 2, 3, 0, 0, 0, 0, "bp_add");
    out_ready = 0; in_valid = 1; fop = 8; rdb = 9;
    repeat (3) begin
      tick;
      check("bp_hold", 64'({out_valid, in_ready, result}), {1'b1, 1'b0, 32'd3});
    end
    out_ready = 1;
    #1;
    check("bp_ready", 64'(in_ready), 1);
    tick;
    check("bp_next", 64'({out_valid, result}), {1'b1, 32'd9});
    in_valid = 0;
    tick;

    // kill drops a held result; kill beats a simultaneous accept
    run_op(0, 1, 2, 3, 0, 0, 0, 0, "kh_add");
    out_ready = 0;
    tick;
    kill = 1;
    tick;
    kill = 0; out_ready = 1;
    check("kill_hold", 64'({out_valid, in_ready}), 64'b01);
    in_valid = 1; kill = 1; fop = 0; rda = 4; rdb = 4;
    tick;
    in_valid = 0; kill = 0;
    check("kill_accept", 64'(out_valid), 0);
    tick;
    check("kill_accept2", 64'(out_valid), 0);
`ifdef ALU_MULDIV_EN
    in_valid = 1; fop = 9; rda = 32'hFFFF_FFFF; rdb = 2;
    tick;
    in_valid = 0;
    repeat (9) tick;
    kill = 1;
    tick;
    kill = 0;
    check("kill_busy", 64'({out_valid, in_ready}), 64'b01);
    seen = 0;
    repeat (40) begin
      tick;
      seen |= out_valid;
    end
    check("kill_noresult", 64'(seen), 0);
`endif

    for (int i = 0; i < 150; i++) begin
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      model(f, a, b, r, v, c);
      run_op(f, a, b, r, r == 0, r[31], v, c, $sformatf("rnd%0d_f%0d", i, f));
      hold = result;
      out_ready = 0;
      repeat ($urandom_range(0, 2)) begin
        tick;
        check("rnd_hold", 64'({out_valid, result}), {1'b1, hold});
      end
      out_ready = 1;
    end

    // asynchronous reset with state and flags non-zero
    run_op(0, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 1, 1, 0, "pre_rst");
`ifdef ALU_MULDIV_EN
    in_valid = 1; fop = 11; rda = 100; rdb = 7;
    tick;
    in_valid = 0;
    repeat (5) tick;
`else
    out_ready = 0;
    tick;
`endif
    #2 nrst = 0;
    #1;
    check("arst_out", 64'({out_valid, in_ready, result, Z, N, V, C}), 0);
    tick;
    nrst = 1; out_ready = 1;
    tick;
    check("arst_idle", 64'({out_valid, in_ready}), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
